// File: rtl/result_packet_tx_pkg.sv
// Shared types and constants for the result packet transmitter.
// RESULT_TX_CHECKSUM_EN adds the CSUM state for the XOR trailer byte.
package result_packet_tx_pkg;

  // Opcode as defined by the model manager.
  typedef logic [7:0] opcode_t;

  localparam logic [7:0] HdrByteDefault = 8'hA5;

  // Byte offsets of the packet fields.
  localparam int unsigned OffHdr     = 0;
  localparam int unsigned OffOpc     = 1;
  localparam int unsigned OffLen     = 2;
  localparam int unsigned LenBytes   = 4;
  localparam int unsigned OffPayload = OffLen + LenBytes;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StOpc,
    StLen,
    StFetch,
    StData,
`ifdef RESULT_TX_CHECKSUM_EN
    StCsum,
`endif
    StFin
  } result_tx_state_t;

  // Inclusive region size; an inverted region is empty.
  function automatic logic [32:0] word_count(input logic [31:0] first, input logic [31:0] last);
    if (last >= first) begin
      return {1'b0, last} - {1'b0, first} + 33'd1;
    end
    return '0;
  endfunction

endpackage

// File: rtl/result_packet_tx_if.sv
// Request, memory-read and byte-stream signals of the result packet transmitter.
// master is the transmitter's view, slave the surrounding logic's view.
interface result_packet_tx_if #(
  parameter int unsigned ADDR_W = 26
) ();
  import result_packet_tx_pkg::*;

  logic              send_req;
  opcode_t           send_opcode;
  logic [ADDR_W-1:0] send_begin;
  logic [ADDR_W-1:0] send_end;
  logic              send_ack;
  logic              busy;
  logic              send_done;

  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_valid;
  logic [31:0]       mem_rd_data;

  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  send_req, send_opcode, send_begin, send_end, mem_rd_valid, mem_rd_data, tx_ready,
    output send_ack, busy, send_done, mem_rd_req, mem_addr, tx_data, tx_valid
  );

  modport slave (
    output send_req, send_opcode, send_begin, send_end, mem_rd_valid, mem_rd_data, tx_ready,
    input  send_ack, busy, send_done, mem_rd_req, mem_addr, tx_data, tx_valid
  );

endinterface

// File: rtl/result_packet_tx_tx_byte_serializer.sv
// Byte serializer: holds a 32-bit word or a single byte and shifts it out MSB-first
// under a valid/ready handshake.
module tx_byte_serializer (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        load_word_i,
  input  logic        load_byte_i,
  input  logic [31:0] word_i,
  input  logic [7:0]  byte_i,
  input  logic        ready_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        xfer_o,
  output logic        last_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;     // bytes remaining after the current one
  logic        valid_q, valid_d;

  assign data_o  = shift_q[31:24];
  assign valid_o = valid_q;
  assign xfer_o  = valid_q & ready_i;
  assign last_o  = (cnt_q == 2'd0);

  // A load wins over the final transfer so back-to-back fields stream without a gap.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_word_i) begin
      shift_d = word_i;
      cnt_d   = 2'd3;
      valid_d = 1'b1;
    end else if (load_byte_i) begin
      shift_d = {byte_i, 24'h0};
      cnt_d   = 2'd0;
      valid_d = 1'b1;
    end else if (xfer_o) begin
      if (cnt_q == 2'd0) begin
        valid_d = 1'b0;
      end else begin
        shift_d = {shift_q[23:0], 8'h0};
        cnt_d   = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/result_packet_tx.sv
// Reads an output memory region word by word and frames it as a result packet byte stream.
// Define RESULT_TX_CHECKSUM_EN to append an XOR checksum byte over the payload.
module result_packet_tx
  import result_packet_tx_pkg::*;
#(
  parameter int unsigned ADDR_W   = 26,
  parameter int unsigned DATA_W   = 32,
  parameter logic [7:0]  HDR_BYTE = HdrByteDefault
) (
  input logic                clk,
  input logic                rst_l,
  result_packet_tx_if.master pkt_io
);

  result_tx_state_t  state_q, state_d;
  opcode_t           opcode_q, opcode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              ack_q;

  logic              capture;
  logic              ser_load_word, ser_load_byte;
  logic [31:0]       ser_word;
  logic [7:0]        ser_byte;
  logic [7:0]        ser_data;
  logic              ser_valid, ser_xfer, ser_last;
  logic [DATA_W-1:0] rd_word;

`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign capture = (state_q == StIdle) && pkt_io.send_req;
  assign rd_word = pkt_io.mem_rd_data;

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    addr_d        = addr_q;
    words_d       = words_q;
    ser_load_word = 1'b0;
    ser_load_byte = 1'b0;
    ser_word      = '0;
    ser_byte      = '0;
    pkt_io.mem_rd_req = 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          opcode_d      = pkt_io.send_opcode;
          addr_d        = pkt_io.send_begin;
          words_d       = (ADDR_W + 1)'(word_count(32'(pkt_io.send_begin), 32'(pkt_io.send_end)));
          ser_load_byte = 1'b1;
          ser_byte      = HDR_BYTE;
          state_d       = StHdr;
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d        = '0;
`endif
        end
      end
      StHdr: begin
        if (ser_xfer) begin
          ser_load_byte = 1'b1;
          ser_byte      = opcode_q;
          state_d       = StOpc;
        end
      end
      StOpc: begin
        if (ser_xfer) begin
          ser_load_word = 1'b1;
          ser_word      = 32'(words_q);
          state_d       = StLen;
        end
      end
      StLen: begin
        if (ser_xfer && ser_last) begin
          if (words_q != '0) begin
            state_d = StFetch;
          end else begin
`ifdef RESULT_TX_CHECKSUM_EN
            ser_load_byte = 1'b1;
            ser_byte      = csum_q;
            state_d       = StCsum;
`else
            state_d       = StFin;
`endif
          end
        end
      end
      StFetch: begin
        pkt_io.mem_rd_req = 1'b1;
        if (pkt_io.mem_rd_valid) begin
          ser_load_word = 1'b1;
          ser_word      = 32'(rd_word);
          state_d       = StData;
        end
      end
      StData: begin
        if (ser_xfer) begin
`ifdef RESULT_TX_CHECKSUM_EN
          csum_d = csum_q ^ ser_data;
`endif
          if (ser_last) begin
            words_d = words_q - 1'b1;
            if (words_d != '0) begin
              addr_d  = addr_q + 1'b1;
              state_d = StFetch;
            end else begin
`ifdef RESULT_TX_CHECKSUM_EN
              ser_load_byte = 1'b1;
              ser_byte      = csum_d;
              state_d       = StCsum;
`else
              state_d       = StFin;
`endif
            end
          end
        end
      end
`ifdef RESULT_TX_CHECKSUM_EN
      StCsum: begin
        if (ser_xfer) begin
          state_d = StFin;
        end
      end
`endif
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      addr_q   <= '0;
      words_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      ack_q    <= capture;
    end
  end

`ifdef RESULT_TX_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  tx_byte_serializer u_ser (
    .clk         (clk),
    .rst_l       (rst_l),
    .load_word_i (ser_load_word),
    .load_byte_i (ser_load_byte),
    .word_i      (ser_word),
    .byte_i      (ser_byte),
    .ready_i     (pkt_io.tx_ready),
    .data_o      (ser_data),
    .valid_o     (ser_valid),
    .xfer_o      (ser_xfer),
    .last_o      (ser_last)
  );

  assign pkt_io.tx_data   = ser_data;
  assign pkt_io.tx_valid  = ser_valid;
  assign pkt_io.send_ack  = ack_q;
  assign pkt_io.busy      = (state_q != StIdle) && (state_q != StFin);
  assign pkt_io.send_done = (state_q == StFin);
  assign pkt_io.mem_addr  = addr_q;

endmodule

// File: tb/tb_result_packet_tx.sv
// Bench for result_packet_tx: vector table, corner sequences and randomized packets
// checked against a byte-queue reference model.
module tb_result_packet_tx;
  import result_packet_tx_pkg::*;

  localparam int unsigned AW = 26;
  localparam logic [AW-1:0] AMax = '1;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam bit CsOn = 1'b1;
`else
  localparam bit CsOn = 1'b0;
`endif

  typedef logic [7:0]    bq_t[$];
  typedef logic [AW-1:0] aq_t[$];

  typedef struct {
    logic [7:0]    op;
    logic [AW-1:0] b;
    logic [AW-1:0] e;
    int            lat;
    bit            bp;
    logic [31:0]   exp_n;
    logic [7:0]    exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  result_packet_tx_if #(.ADDR_W(AW)) bus ();

  result_packet_tx #(.ADDR_W(AW), .DATA_W(32), .HDR_BYTE(8'hA5)) dut (
    .clk    (clk),
    .rst_l  (rst_l),
    .pkt_io (bus)
  );

  int errors = 0;
  int checks = 0;
  int mem_lat = 0;
  bit bp = 1'b0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int proto_err = 0;
  bq_t got;
  aq_t rd_q;
  logic [31:0] mem_over [logic [AW-1:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Packet = A5, opcode, 32-bit big-endian N, N words big-endian, optional XOR trailer.
  function automatic void build_expected(input logic [7:0] op, input logic [AW-1:0] b,
                                         input logic [AW-1:0] e, output bq_t xb, output aq_t xa);
    logic [63:0]   n;
    logic [31:0]   w;
    logic [7:0]    cs;
    logic [AW-1:0] a;
    xb = {};
    xa = {};
    cs = 8'h00;
    n  = (e >= b) ? (64'(e) - 64'(b) + 64'd1) : 64'd0;
    xb.push_back(8'hA5);
    xb.push_back(op);
    for (int k = 3; k >= 0; k--) xb.push_back(n[8*k +: 8]);
    for (longint unsigned i = 0; i < n; i++) begin
      a = AW'(64'(b) + i);
      xa.push_back(a);
      w = mem_word(a);
      for (int k = 3; k >= 0; k--) begin
        xb.push_back(w[8*k +: 8]);
        cs ^= w[8*k +: 8];
      end
    end
    if (CsOn) xb.push_back(cs);
  endfunction

  // Memory responder: one read at a time, fixed latency, plus stray valid pulses when idle.
  initial begin
    bit pending;
    int cnt;
    logic [AW-1:0] a;
    pending = 1'b0;
    cnt = 0;
    a = '0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      if (!rst_l) begin
        pending = 1'b0;
        continue;
      end
      if (pending) begin
        if (bus.mem_rd_req !== 1'b1 || bus.mem_addr !== a) proto_err++;
      end else if (bus.mem_rd_req === 1'b1) begin
        pending = 1'b1;
        cnt = mem_lat;
        a = bus.mem_addr;
        rd_q.push_back(a);
      end else if ($urandom_range(0, 7) == 0) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = $urandom;
      end
      if (pending) begin
        if (cnt == 0) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = mem_word(a);
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Byte sink: drives tx_ready, records accepted bytes, checks stall stability.
  initial begin
    logic [7:0] hold;
    bit stalled;
    hold = '0;
    stalled = 1'b0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        stalled = 1'b0;
        bus.tx_ready = 1'b0;
        continue;
      end
      if (stalled && (bus.tx_valid !== 1'b1 || bus.tx_data !== hold)) proto_err++;
      if (bus.send_ack === 1'b1) ack_cnt++;
      if (bus.send_done === 1'b1) done_cnt++;
      bus.tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.tx_valid === 1'b1 && bus.tx_ready) got.push_back(bus.tx_data);
      stalled = (bus.tx_valid === 1'b1) && !bus.tx_ready;
      hold = bus.tx_data;
    end
  end

  task automatic run_packet(input string name, input logic [7:0] op, input logic [AW-1:0] b,
                            input logic [AW-1:0] e, input int lat, input bit bpv,
                            output bq_t pkt);
    bq_t xb;
    aq_t xa;
    int t;
    int mism;
    build_expected(op, b, e, xb, xa);
    @(negedge clk);
    mem_lat = lat;
    bp = bpv;
    got.delete();
    rd_q.delete();
    ack_cnt = 0;
    done_cnt = 0;
    proto_err = 0;
    bus.send_req    = 1'b1;
    bus.send_opcode = op;
    bus.send_begin  = b;
    bus.send_end    = e;
    @(negedge clk);
    check({name, " ack"}, 64'(bus.send_ack), 64'd1);
    check({name, " busy"}, 64'(bus.busy), 64'd1);
    bus.send_req    = 1'b0;
    bus.send_opcode = $urandom;
    bus.send_begin  = AW'($urandom);
    bus.send_end    = AW'($urandom);
    for (t = 0; t < 3000 && done_cnt == 0; t++) begin
      if (t == 2) bus.send_req = 1'b1;
      if (t == 3) bus.send_req = 1'b0;
      @(negedge clk);
    end
    bus.send_req = 1'b0;
    repeat (3) @(negedge clk);
    check({name, " done count"}, 64'(done_cnt), 64'd1);
    check({name, " ack count"}, 64'(ack_cnt), 64'd1);
    check({name, " idle busy"}, 64'(bus.busy), 64'd0);
    check({name, " byte count"}, 64'(got.size()), 64'(xb.size()));
    mism = -1;
    for (int i = 0; i < xb.size() && i < got.size(); i++) begin
      if (mism < 0 && got[i] !== xb[i]) mism = i;
    end
    checks++;
    if (mism >= 0) begin
      errors++;
      $display("FAIL %s bytes: byte %0d got %0h expected %0h", name, mism, got[mism], xb[mism]);
    end
    check({name, " read count"}, 64'(rd_q.size()), 64'(xa.size()));
    for (int i = 0; i < xa.size() && i < rd_q.size(); i++) begin
      check($sformatf("%s read addr %0d", name, i), 64'(rd_q[i]), 64'(xa[i]));
    end
    check({name, " protocol"}, 64'(proto_err), 64'd0);
    if (done_cnt == 0) begin
      rst_l = 1'b0;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
    end
    pkt = got;
  endtask

  vec_t vecs[6];

  initial begin
    bq_t pkt;
    logic [31:0] n_got;
    logic [7:0] op;
    logic [AW-1:0] b, e;
    int len;
    int t;

    bus.send_req    = 1'b0;
    bus.send_opcode = '0;
    bus.send_begin  = '0;
    bus.send_end    = '0;

    mem_over[AW'(26'h100)]  = 32'h11223344;
    mem_over[AW'(26'h101)]  = 32'hAABBCCDD;
    mem_over[AW'(26'h200)]  = 32'h01020304;
    mem_over[AW'(26'h201)]  = 32'h10203040;
    mem_over[AMax]          = 32'hCAFEF00D;

    vecs[0] = '{8'h03, AW'(26'h100), AW'(26'h101), 0, 1'b0, 32'd2, CsOn ? 8'h44 : 8'hDD};
    vecs[1] = '{8'h03, AW'(26'h100), AW'(26'h101), 2, 1'b1, 32'd2, CsOn ? 8'h44 : 8'hDD};
    vecs[2] = '{8'h5A, AW'(26'h20),  AW'(26'h1F),  1, 1'b0, 32'd0, 8'h00};
    vecs[3] = '{8'hC1, AMax,         AW'(0),       5, 1'b1, 32'd0, 8'h00};
    vecs[4] = '{8'h99, AMax,         AMax,         5, 1'b0, 32'd1, CsOn ? 8'hC9 : 8'h0D};
    vecs[5] = '{8'h7E, AW'(26'h200), AW'(26'h201), 3, 1'b1, 32'd2, CsOn ? 8'h44 : 8'h40};

    repeat (3) @(negedge clk);
    check("reset tx", 64'({bus.tx_valid, bus.tx_data}), 64'd0);
    check("reset ctl", 64'({bus.send_ack, bus.busy, bus.send_done, bus.mem_rd_req, bus.mem_addr}),
          64'd0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_packet($sformatf("vec%0d", i), vecs[i].op, vecs[i].b, vecs[i].e, vecs[i].lat,
                 vecs[i].bp, pkt);
      n_got = (pkt.size() >= 6) ? {pkt[OffLen], pkt[OffLen+1], pkt[OffLen+2], pkt[OffLen+3]}
                                : 32'hFFFF_FFFF;
      check($sformatf("vec%0d length field", i), 64'(n_got), 64'(vecs[i].exp_n));
      check($sformatf("vec%0d last byte", i), 64'((pkt.size() > 0) ? pkt[pkt.size()-1] : 8'hxx),
            64'(vecs[i].exp_last));
      check($sformatf("vec%0d header", i), 64'((pkt.size() > 1) ? {pkt[OffHdr], pkt[OffOpc]} : 16'h0),
            64'({8'hA5, vecs[i].op}));
    end

    // Reset while the second byte of the first data word is pending.
    @(negedge clk);
    mem_lat = 0;
    bp = 1'b0;
    got.delete();
    bus.send_req    = 1'b1;
    bus.send_opcode = 8'h03;
    bus.send_begin  = AW'(26'h100);
    bus.send_end    = AW'(26'h101);
    @(negedge clk);
    bus.send_req = 1'b0;
    for (t = 0; t < 200 && got.size() < OffPayload + 2; t++) @(negedge clk);
    check("midreset reached data", 64'(got.size()), 64'(OffPayload + 2));
    #2 rst_l = 1'b0;
    #1;
    check("midreset tx", 64'({bus.tx_valid, bus.tx_data}), 64'd0);
    check("midreset ctl",
          64'({bus.send_ack, bus.busy, bus.send_done, bus.mem_rd_req, bus.mem_addr}), 64'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    run_packet("after reset", 8'h03, AW'(26'h100), AW'(26'h101), 0, 1'b1, pkt);

    for (int i = 0; i < 24; i++) begin
      op  = $urandom;
      len = $urandom_range(0, 5);
      b   = ($urandom_range(0, 3) == 0) ? AMax - AW'($urandom_range(0, 3)) : AW'($urandom);
      if (len == 0) begin
        if (b < AW'(8)) b = b + AW'(8);
        e = b - AW'(1) - AW'($urandom_range(0, 3));
      end else begin
        e = b + AW'(len - 1);
      end
      run_packet($sformatf("rand%0d", i), op, b, e, $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), pkt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
